// File: rtl/trig_busy_responder_if.sv
// Event-record stream of trig_busy_responder: the responder is the master,
// the event consumer is the slave.
interface trig_busy_responder_if;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_trigNum;
  logic [31:0] evt_timestamp;

  modport master (
    output evt_valid,
    output evt_trigNum,
    output evt_timestamp,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_trigNum,
    input  evt_timestamp,
    output evt_ready
  );
endinterface

// File: rtl/trig_busy_responder.sv
// Trigger responder: synchronises trigIn, accepts edges into a FWFT event FIFO,
// applies a per-trigger dead time and reports busy. Define TRIG_BUSY_TIMESTAMP_EN for timestamps.
module trig_busy_responder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         trigIn,
  input  logic                         enable,
  input  logic [15:0]                  holdoff,
  output logic                         busyOut,
  trig_busy_responder_if.master        evt,
  output logic [31:0]                  trig_count,
  output logic [15:0]                  drop_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
`ifdef TRIG_BUSY_TIMESTAMP_EN
  localparam int ENTRY_W = 64;
`else
  localparam int ENTRY_W = 32;
`endif

  typedef enum logic {
    IDLE,
    HOLDOFF
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   trig_edge_q, trig_edge_d;
  state_e                 state_q, state_d;
  logic [15:0]            hold_cnt_q, hold_cnt_d;
  logic [31:0]            trig_count_q, trig_count_d;
  logic [15:0]            drop_count_q, drop_count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;

  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]     push_data;
  logic [ENTRY_W-1:0]     head;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   not_empty;

  assign not_empty = (level_q != '0);
  assign accept    = trig_edge_q && enable && (state_q == IDLE) && (level_q < LW'(FIFO_DEPTH));
  assign push      = accept;
  assign pop       = not_empty && evt.evt_ready;

`ifdef TRIG_BUSY_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;

  assign ts_d      = ts_q + 32'd1;
  assign push_data = {ts_q, trig_count_q};

  always_ff @(posedge clock) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end
`else
  assign push_data = trig_count_q;
`endif

  always_comb begin
    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    sync_d       = {sync_q[SYNC_STAGES-2:0], trigIn};
    prev_d       = sync_q[SYNC_STAGES-1];
    trig_edge_d  = sync_q[SYNC_STAGES-1] & ~prev_q;
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    trig_count_d = trig_count_q;
    drop_count_d = drop_count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;

    // Counter is loaded with holdoff-1 so HOLDOFF lasts exactly holdoff cycles.
    case (state_q)
      IDLE: begin
        if (accept && (holdoff != 16'd0)) begin
          state_d    = HOLDOFF;
          hold_cnt_d = holdoff - 16'd1;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q == 16'd0) state_d = IDLE;
        else                     hold_cnt_d = hold_cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (accept) trig_count_d = trig_count_q + 32'd1;
    if (trig_edge_q && enable && !accept && (drop_count_q != 16'hFFFF))
      drop_count_d = drop_count_q + 16'd1;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      trig_edge_q  <= 1'b0;
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      trig_count_q <= '0;
      drop_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      trig_edge_q  <= trig_edge_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      trig_count_q <= trig_count_d;
      drop_count_q <= drop_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy lives in level_q and read data is gated by evt_valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head              = mem_q[rd_ptr_q];
  assign evt.evt_valid     = not_empty;
  assign evt.evt_trigNum   = not_empty ? head[31:0] : 32'd0;
`ifdef TRIG_BUSY_TIMESTAMP_EN
  assign evt.evt_timestamp = not_empty ? head[63:32] : 32'd0;
`else
  assign evt.evt_timestamp = 32'd0;
`endif

  assign busyOut    = !enable || (state_q == HOLDOFF) || (level_q >= LW'(FIFO_DEPTH - 1));
  assign trig_count = trig_count_q;
  assign drop_count = drop_count_q;
  assign fifo_level = level_q;

endmodule
